// File: rtl/scale_sched_pkg.sv
// Shared types and constants for the reciprocal-scale request scheduler.
package scale_sched_pkg;

   localparam int unsigned NUM_REQ_DEFAULT        = 4;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;

   // Numerator of the reciprocal scale: 127 << 24.
   localparam logic [31:0] DIVIDEND = 32'd2130706432;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StResp  = 2'd3
   } state_e;

   // Index width that never collapses to zero bits.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scale_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after rr_ptr_i, wrapping.
module rr_arbiter
   import scale_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
   parameter int unsigned IdxW    = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IdxW-1:0]    rr_ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IdxW-1:0]    grant_idx_o,
   output logic               valid_o
);

   // One extra bit so ptr + offset never overflows before the wrap.
   localparam int unsigned CandW = IdxW + 1;

   logic [CandW-1:0] cand;
   logic             found;

   // Scan offsets 0..NUM_REQ-1 from the pointer and keep the first hit.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      cand        = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_i} + CandW'(k);
         if (cand >= CandW'(NUM_REQ)) begin
            cand = cand - CandW'(NUM_REQ);
         end
         if (!found && req_i[cand[IdxW-1:0]]) begin
            found                    = 1'b1;
            grant_idx_o              = cand[IdxW-1:0];
            grant_o[cand[IdxW-1:0]]  = 1'b1;
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/scale_scheduler.sv
// Shares one external reciprocal-scale divider among NUM_REQ requesters.
// Optional per-requester result cache: define SCALE_SCHED_CACHE_EN.
module scale_scheduler
   import scale_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ        = NUM_REQ_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*32-1:0] req_max_abs,
   output logic [NUM_REQ-1:0]    resp_valid,
   output logic [31:0]           resp_scale,
   output logic                  resp_err,
   output logic                  div_start,
   output logic [31:0]           div_max_abs,
   input  logic                  div_ready,
   input  logic [31:0]           div_result,
   output logic                  busy
);

   localparam int unsigned IdxW = idx_width(NUM_REQ);
   localparam int unsigned CntW = idx_width(TIMEOUT_CYCLES);
   // Last WAIT cycle: the counter would reach TIMEOUT_CYCLES-1 on the next edge.
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 2);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_REQ - 1);

   state_e            state_q, state_d;
   logic [IdxW-1:0]   grant_q, grant_d;
   logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [31:0]       op_q, op_d;
   logic [31:0]       scale_q, scale_d;
   logic              err_q, err_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic [NUM_REQ-1:0] arb_grant;
   logic [IdxW-1:0]    arb_idx;
   logic               arb_valid;
   logic [31:0]        arb_op;

   logic               cache_hit;
   logic [31:0]        cache_scale;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IdxW    (IdxW)
   ) u_arb (
      .req_i       (req),
      .rr_ptr_i    (rr_ptr_q),
      .grant_o     (arb_grant),
      .grant_idx_o (arb_idx),
      .valid_o     (arb_valid)
   );

   // AND-OR mux of the granted requester's operand.
   always_comb begin
      arb_op = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) begin
            arb_op = arb_op | req_max_abs[32*i +: 32];
         end
      end
   end

`ifdef SCALE_SCHED_CACHE_EN
   logic [NUM_REQ-1:0] cache_vld_q;
   logic [31:0]        cache_op_q    [NUM_REQ];
   logic [31:0]        cache_scale_q [NUM_REQ];
   logic               cache_fill;

   // Only a real divider answer refreshes an entry; timeouts never do.
   assign cache_fill = (state_q == StWait) && div_ready;

   // Valid bits are the only cache state that reset must clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cache_vld_q <= '0;
      end else if (cache_fill) begin
         cache_vld_q[grant_q] <= 1'b1;
      end
   end

   // Entry payload, qualified by the valid bits above.
   always_ff @(posedge clk) begin
      if (cache_fill) begin
         cache_op_q[grant_q]    <= op_q;
         cache_scale_q[grant_q] <= div_result;
      end
   end

   assign cache_hit   = cache_vld_q[arb_idx] && (cache_op_q[arb_idx] == arb_op);
   assign cache_scale = cache_scale_q[arb_idx];
`else
   assign cache_hit   = 1'b0;
   assign cache_scale = '0;
`endif

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         op_q     <= '0;
         scale_q  <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         op_q     <= op_d;
         scale_q  <= scale_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign div_max_abs = op_q;

   // Next-state and output decode.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      op_d       = op_q;
      scale_d    = scale_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      resp_valid = '0;
      resp_scale = '0;
      resp_err   = 1'b0;
      div_start  = 1'b0;
      busy       = (state_q != StIdle);

      unique case (state_q)
         StIdle: begin
            if (arb_valid) begin
               grant_d = arb_idx;
               op_d    = arb_op;
               if (cache_hit) begin
                  scale_d = cache_scale;
                  err_d   = 1'b0;
                  state_d = StResp;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            div_start = 1'b1;
            cnt_d     = '0;
            state_d   = StWait;
         end
         StWait: begin
            // div_ready is checked first so it wins over a coincident timeout.
            if (div_ready) begin
               scale_d = div_result;
               err_d   = 1'b0;
               state_d = StResp;
            end else if (cnt_q == CntLast) begin
               scale_d = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            resp_valid[grant_q] = 1'b1;
            resp_scale          = scale_q;
            resp_err            = err_q;
            rr_ptr_d            = (grant_q == IdxLast) ? '0 : grant_q + 1'b1;
            state_d             = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule
